// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract sequencer built around a single 4-bit adder slice.
// Operands are captured once, then one nibble per cycle is summed LSB-first
// with the carry chained through a register; the result is held under a
// valid/ready handshake until the consumer takes it.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state, state_nx;
    logic [IW-1:0]             idx;
    logic                      carry;
    // b is stored already inverted for subtract, and carry preloaded with 1,
    // so the slice never needs to know which operation is in flight.
    logic [NIBBLES-1:0][3:0]   a_reg, b_reg, sum_reg;
    logic [4:0]                slice;
    logic                      last;

    assign last  = (idx == IW'(NIBBLES - 1));
    assign slice = {1'b0, a_reg[idx]} + {1'b0, b_reg[idx]} + {4'b0, carry};
    assign sum   = sum_reg;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Handshake/status outputs decoded from state
    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    // Operand capture, nibble-serial datapath and result holding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a;
                        b_reg   <= sub ? ~b : b;
                        carry   <= sub ? 1'b1 : cin;
                        idx     <= '0;
                        sum_reg <= '0;
                    end
                end
                RUN: begin
                    sum_reg[idx] <= slice[3:0];
                    carry        <= slice[4];
                    idx          <= idx + 1'b1;
                    if (last) begin
                        idx       <= '0;
                        cout      <= slice[4];
                        // Same-sign operands producing a different-sign result.
                        ovf       <= (a_reg[NIBBLES-1][3] == b_reg[NIBBLES-1][3]) &&
                                     (slice[3] != a_reg[NIBBLES-1][3]);
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
